// File: rtl/mul_seq_unit_if.sv
// rtl/mul_seq_unit_if.sv - issue/writeback handshake bundle for the sequential multiplier
interface mul_seq_unit_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [1:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        flush_i;
    logic        res_valid_o;
    logic        res_ready_i;
    logic [31:0] result_o;
    logic        busy_o;

    modport slave (
        input  req_valid_i, op_i, a_i, b_i, flush_i, res_ready_i,
        output req_ready_o, res_valid_o, result_o, busy_o
    );

    modport master (
        output req_valid_i, op_i, a_i, b_i, flush_i, res_ready_i,
        input  req_ready_o, res_valid_o, result_o, busy_o
    );
endinterface

// File: rtl/mul_seq_unit.sv
// rtl/mul_seq_unit.sv - radix-2 shift-add RV32M multiplier built on a 32-bit ripple adder
module adder32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        carry_i,
    output logic [31:0] sum_o,
    output logic        carry_o
);
    logic c;

    always_comb begin
        sum_o = '0;
        c     = carry_i;
        for (int i = 0; i < 32; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ c;
            c        = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
        end
        carry_o = c;
    end
endmodule

module mul_seq_unit #(
    parameter int XLEN      = 32,
    parameter bit ZERO_SKIP = 1'b1
) (
    input  logic           clk_i,
    input  logic           rst_i,
    mul_seq_unit_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [1:0]        op_q;
    logic              neg_q;
    logic [XLEN-1:0]   acc_hi_q, acc_lo_q, mcand_q, result_q;
    logic [4:0]        cnt_q;

    logic              accept, zero_op;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN-1:0]   add_sum;
    logic              add_carry;
    logic [XLEN:0]     step;
    logic [2*XLEN-1:0] prod, fixed;

    // MULH treats both operands as signed, MULHSU only rs1
    assign a_neg   = ((bus.op_i == 2'b01) || (bus.op_i == 2'b10)) && bus.a_i[XLEN-1];
    assign b_neg   = (bus.op_i == 2'b01) && bus.b_i[XLEN-1];
    assign mag_a   = a_neg ? (~bus.a_i + XLEN'(1)) : bus.a_i;
    assign mag_b   = b_neg ? (~bus.b_i + XLEN'(1)) : bus.b_i;
    assign zero_op = (bus.a_i == '0) || (bus.b_i == '0);
    assign accept  = (state_q == S_IDLE) && bus.req_valid_i && !bus.flush_i;

    adder32 u_adder (
        .a_i     (acc_hi_q),
        .b_i     (mcand_q),
        .carry_i (1'b0),
        .sum_o   (add_sum),
        .carry_o (add_carry)
    );

    // Adder carry becomes the top bit of the right-shifted accumulator
    assign step  = acc_lo_q[0] ? {add_carry, add_sum} : {1'b0, acc_hi_q};
    assign prod  = {acc_hi_q, acc_lo_q};
    assign fixed = neg_q ? (~prod + (2*XLEN)'(1)) : prod;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = (ZERO_SKIP && zero_op) ? S_FIX : S_CALC;
            S_CALC: if (cnt_q == 5'd31) state_d = S_FIX;
            S_FIX:  state_d = S_DONE;
            S_DONE: if (bus.res_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (bus.flush_i && (state_q != S_IDLE)) state_d = S_IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q     <= '0;
            neg_q    <= 1'b0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            mcand_q  <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_q     <= bus.op_i;
                        neg_q    <= a_neg ^ b_neg;
                        acc_hi_q <= '0;
                        // A skipped zero product still passes through FIX, so clear the low half
                        acc_lo_q <= (ZERO_SKIP && zero_op) ? '0 : mag_b;
                        mcand_q  <= mag_a;
                        cnt_q    <= '0;
                    end
                end
                S_CALC: begin
                    acc_hi_q <= step[XLEN:1];
                    acc_lo_q <= {step[0], acc_lo_q[XLEN-1:1]};
                    cnt_q    <= cnt_q + 5'd1;
                end
                S_FIX: begin
                    if (!bus.flush_i) begin
                        result_q <= (op_q == 2'b00) ? fixed[XLEN-1:0] : fixed[2*XLEN-1:XLEN];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready_o = (state_q == S_IDLE);
    assign bus.res_valid_o = (state_q == S_DONE);
    assign bus.busy_o      = (state_q != S_IDLE);
    assign bus.result_o    = result_q;
endmodule

// File: tb/tb_mul_seq_unit.sv
// tb/tb_mul_seq_unit.sv - randomized self-checking bench for mul_seq_unit
module tb_mul_seq_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mul_seq_unit_if mif ();

    mul_seq_unit u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (mif.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] xa, xb, p;
        xa = ((op == 2'b01) || (op == 2'b10)) ? {{32{a[31]}}, a} : {32'd0, a};
        xb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = xa * xb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int hold);
        int          lat;
        logic        rdy_ok, hold_ok;
        logic [31:0] exp_res, first;
        exp_res = ref_mul(op, a, b);
        @(negedge clk);
        mif.req_valid_i = 1'b1;
        mif.op_i = op;
        mif.a_i  = a;
        mif.b_i  = b;
        @(posedge clk); #1;
        mif.req_valid_i = 1'b0;
        mif.op_i = 2'($urandom);
        mif.a_i  = $urandom;
        mif.b_i  = $urandom;
        lat = 0;
        rdy_ok = 1'b1;
        while (!mif.res_valid_o && lat < 100) begin
            if (mif.req_ready_o) rdy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " latency"}, lat, ((a == 0) || (b == 0)) ? 1 : 33);
        chk({tag, " ready_low"}, {31'd0, rdy_ok}, 1);
        chk({tag, " result"}, mif.result_o, exp_res);
        first = mif.result_o;
        hold_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (!mif.res_valid_o || mif.result_o !== first) hold_ok = 1'b0;
        end
        if (hold > 0) chk({tag, " hold"}, {31'd0, hold_ok}, 1);
        mif.res_ready_i = 1'b1;
        @(posedge clk); #1;
        mif.res_ready_i = 1'b0;
        chk({tag, " back_idle"}, {29'd0, mif.busy_o, mif.res_valid_o, mif.req_ready_o}, 32'd1);
    endtask

    task automatic abort_op(input string tag, input bit use_rst);
        @(negedge clk);
        mif.req_valid_i = 1'b1;
        mif.op_i = 2'b00;
        mif.a_i  = 32'h1234_5678;
        mif.b_i  = 32'h0000_0FFF;
        @(posedge clk); #1;
        mif.req_valid_i = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk({tag, " mid_busy"}, {31'd0, mif.busy_o}, 1);
        if (use_rst) rst = 1'b1; else mif.flush_i = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mif.flush_i = 1'b0;
        chk({tag, " aborted"}, {29'd0, mif.busy_o, mif.res_valid_o, mif.req_ready_o}, 32'd1);
        if (use_rst) chk({tag, " result_cleared"}, mif.result_o, 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
            if (mif.res_valid_o) chk({tag, " no_valid"}, 32'd1, 32'd0);
        end
    endtask

    task automatic blocked_by_flush();
        @(negedge clk);
        mif.req_valid_i = 1'b1;
        mif.flush_i = 1'b1;
        mif.a_i = 32'd9;
        mif.b_i = 32'd9;
        @(posedge clk); #1;
        mif.req_valid_i = 1'b0;
        mif.flush_i = 1'b0;
        chk("flush_blocks_accept", {31'd0, mif.busy_o}, 0);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] corners [6];
        corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_0000};
        return ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
    endfunction

    initial begin
        mif.req_valid_i = 1'b0;
        mif.op_i = 2'b00;
        mif.a_i = '0;
        mif.b_i = '0;
        mif.flush_i = 1'b0;
        mif.res_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {29'd0, mif.busy_o, mif.res_valid_o, mif.req_ready_o}, 32'd1);
        chk("reset_result", mif.result_o, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("mul_7x6",      2'b00, 32'd7, 32'd6, 0);
        run_op("mulhu_ff",     2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("mul_ff",       2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("mulh_min",     2'b01, 32'h8000_0000, 32'h8000_0000, 0);
        run_op("mulh_m1",      2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("mulhsu_m1",    2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("mulhsu_2",     2'b10, 32'd2, 32'h8000_0000, 0);
        run_op("backpressure", 2'b01, 32'hDEAD_BEEF, 32'h1234_5678, 10);
        abort_op("flush", 1'b0);
        run_op("mul_3x5_a",    2'b00, 32'd3, 32'd5, 0);
        abort_op("reset", 1'b1);
        run_op("mul_3x5_b",    2'b00, 32'd3, 32'd5, 0);
        blocked_by_flush();
        run_op("zero_skip",    2'b00, 32'd0, 32'h1234, 2);
        run_op("zero_skip_hs", 2'b01, 32'hFFFF_FFFF, 32'd0, 0);

        for (int n = 0; n < 30; n++) begin
            run_op("rand", 2'($urandom), pick(), pick(), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
